// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, baud engine, drain interrupt.
module bus_uart_tx #(
  parameter logic [31:0] BaseAddress  = 32'h1000_0000,
  parameter int          FifoDepth    = 8,
  parameter logic [15:0] DivisorReset = 16'd868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ack,
  output logic        hit,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FifoDepth);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FifoDepth);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]  mem_q [FifoDepth];
  logic [AW:0] wr_ptr_q, rd_ptr_q, count;
  logic        full, empty;
  logic [1:0]  sel;
  logic        acc_rd, acc_wr, push_req, push, pop, ovf_clr;
  logic [15:0] div_q, period, baud_q;
  logic        baud_done;
  logic [1:0]  ctrl_q;
  logic        ovf_q;
  state_t      state_q;
  logic [7:0]  shift_q, head;
  logic [2:0]  bit_q;
  logic        tx_q, irq_q, ack_q;
  logic [31:0] rdata_q, rdata_d;
  logic        unused_bits;

  assign unused_bits = ^{address[1:0], byte_enable[3:2], write_data[31:16]};

  assign hit      = (address[31:4] == BaseAddress[31:4]);
  assign sel      = address[3:2];
  assign acc_wr   = hit & write;
  assign acc_rd   = hit & read & ~write;
  assign push_req = acc_wr & (sel == 2'd0) & byte_enable[0];
  assign push     = push_req & ~full;
  assign ovf_clr  = acc_wr & (sel == 2'd1) & byte_enable[0] & write_data[3];

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // A zero divisor still gives a one-clock bit period.
  assign period    = (div_q == 16'd0) ? 16'd1 : div_q;
  assign baud_done = (baud_q == 16'd0);

  // Pop when idle, or on the final stop cycle to chain frames without a gap.
  assign pop = ctrl_q[0] & ~empty &
               ((state_q == IDLE) | ((state_q == STOP) & baud_done));

  assign read_data = rdata_q;
  assign ack       = ack_q;
  assign tx        = tx_q;
  assign irq       = irq_q;

  // Register read mux.
  always_comb begin
    rdata_d = '0;
    case (sel)
      2'd1: rdata_d = {16'd0, 8'(count), 4'd0,
                       ovf_q, (state_q != IDLE), empty, full};
      2'd2: rdata_d = {16'd0, div_q};
      2'd3: rdata_d = {30'd0, ctrl_q};
      default: rdata_d = '0;
    endcase
  end

  // Bus acknowledge and registered read data (held between reads).
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= hit & (read | write);
      if (acc_rd) rdata_q <= rdata_d;
    end
  end

  // Control registers and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= DivisorReset;
      ctrl_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (acc_wr && sel == 2'd2) begin
        if (byte_enable[0]) div_q[7:0]  <= write_data[7:0];
        if (byte_enable[1]) div_q[15:8] <= write_data[15:8];
      end
      if (acc_wr && sel == 2'd3 && byte_enable[0]) ctrl_q <= write_data[1:0];
      if (push_req && full) ovf_q <= 1'b1;
      else if (ovf_clr)     ovf_q <= 1'b0;
    end
  end

  // FIFO pointers; fullness is judged before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= write_data[7:0];
  end

  // Transmit FSM; period is sampled at every bit start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tx_q    <= 1'b1;
      baud_q  <= '0;
      shift_q <= '0;
      bit_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q <= head;
            state_q <= START;
            tx_q    <= 1'b0;
            baud_q  <= period - 16'd1;
          end
        end
        START: begin
          if (baud_done) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
            baud_q  <= period - 16'd1;
          end else baud_q <= baud_q - 16'd1;
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= period - 16'd1;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
            end
          end else baud_q <= baud_q - 16'd1;
        end
        STOP: begin
          if (baud_done) begin
            if (pop) begin
              shift_q <= head;
              state_q <= START;
              tx_q    <= 1'b0;
              baud_q  <= period - 16'd1;
            end else begin
              state_q <= IDLE;
              tx_q    <= 1'b1;
            end
          end else baud_q <= baud_q - 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Drain interrupt; a push this cycle suppresses it immediately.
  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= ctrl_q[1] & empty & (state_q == IDLE) & ~push;
  end

endmodule

// File: tb/tb_bus_uart_tx.sv
// Randomised bench for bus_uart_tx with a frame-level reference model.
module tb_bus_uart_tx;
  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] address = '0, write_data = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] read_data;
  logic        ack, hit, tx, irq;

  int checks = 0, errors = 0;
  logic [7:0]  mq[$];
  logic [15:0] div_m;

  bus_uart_tx dut (
    .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
    .byte_enable(byte_enable), .write_data(write_data), .read_data(read_data),
    .ack(ack), .hit(hit), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d,
                        output logic ackv);
    @(negedge clk); address = a; write = 1'b1; byte_enable = be; write_data = d;
    @(posedge clk); #1; ackv = ack; write = 1'b0; byte_enable = '0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d, output logic ackv);
    @(negedge clk); address = a; read = 1'b1;
    @(posedge clk); #1; ackv = ack; d = read_data; read = 1'b0;
  endtask

  // Waits (bounded) for a start bit, then records n cycles of tx from it.
  task automatic capture(input int n, output logic [255:0] s, output logic found);
    found = 1'b0; s = '1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (tx === 1'b0) found = 1'b1;
    end
    if (found) begin
      s[0] = 1'b0;
      for (int i = 1; i < n; i++) begin @(posedge clk); #1; s[i] = tx; end
    end
  endtask

  // Expected line level for cycle idx of back-to-back 8N1 frames.
  function automatic logic line_bit(input logic [7:0] b[$], input int per, input int idx);
    int f, k;
    f = idx / (10 * per);
    k = (idx % (10 * per)) / per;
    if (f >= b.size()) return 1'b1;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return b[f][k-1];
  endfunction

  function automatic logic [31:0] status_m(input bit busy, input bit ovf);
    return {16'd0, 8'(mq.size()), 4'd0, ovf, busy, (mq.size() == 0), (mq.size() == DEPTH)};
  endfunction

  task automatic test_reset();
    logic [31:0] d; logic a;
    rst = 1'b1; repeat (3) @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (ack !== 1'b0 || read_data !== 32'd0) begin errors++;
      $display("FAIL reset_bus ack %b rdata %h want 0/0", ack, read_data); end
    @(negedge clk); rst = 1'b0;
    bus_rd(BASE + 4, d, a);
    checks++; if (d !== 32'h2 || a !== 1'b1) begin errors++;
      $display("FAIL reset_status got %h ack %b want 00000002", d, a); end
    bus_rd(BASE + 8, d, a);
    checks++; if (d !== 32'd868) begin errors++; $display("FAIL reset_divisor got %0d want 868", d); end
    div_m = 16'd868;
    bus_rd(BASE + 12, d, a);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL reset_ctrl got %h want 0", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d, v, held; logic a; logic [3:0] be;
    for (int i = 0; i < 4; i++) begin
      v = $urandom; be = 4'($urandom);
      bus_wr(BASE + 8, be, v, a);
      if (be[0]) div_m[7:0]  = v[7:0];
      if (be[1]) div_m[15:8] = v[15:8];
      bus_rd(BASE + 8 + 32'(i % 4), d, a);
      checks++; if (d !== {16'd0, div_m}) begin errors++;
        $display("FAIL divisor_lanes be %b got %h want %h", be, d, {16'd0, div_m}); end
    end
    bus_rd(BASE + 0, d, a);
    checks++; if (d !== 32'd0 || a !== 1'b1) begin errors++;
      $display("FAIL txdata_read got %h ack %b want 0/1", d, a); end
    @(negedge clk); address = BASE + 32'h10; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_above got %b want 0", hit); end
    address = BASE + 32'hF; #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_top got %b want 1", hit); end
    // Simultaneous read+write: write happens, read data held, single ack.
    bus_rd(BASE + 8, held, a);
    @(negedge clk); address = BASE + 12; read = 1'b1; write = 1'b1;
    byte_enable = 4'h1; write_data = 32'h2;
    @(posedge clk); #1; a = ack; d = read_data; read = 1'b0; write = 1'b0; byte_enable = '0;
    checks++; if (a !== 1'b1 || d !== held) begin errors++;
      $display("FAIL rw_same ack %b rdata %h want 1/%h", a, d, held); end
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL ack_single got %b want 0", ack); end
    bus_rd(BASE + 12, d, a);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL rw_ctrl got %h want 2", d); end
    bus_wr(BASE + 12, 4'h1, 32'h0, a);
  endtask

  task automatic test_frame();
    logic [31:0] d, dm; logic a, found; logic [255:0] s; logic [7:0] b[$]; int per, bad;
    bus_wr(BASE + 12, 4'h1, 32'h1, a);
    for (int it = 0; it < 5; it++) begin
      div_m = (it == 0) ? 16'd4 : (it == 1) ? 16'd0 : 16'($urandom_range(1, 5));
      per = (div_m == 0) ? 1 : int'(div_m);
      b.delete(); b.push_back((it == 0) ? 8'h55 : 8'($urandom));
      bus_wr(BASE + 8, 4'h3, {16'd0, div_m}, a);
      bus_wr(BASE + 0, 4'h1, {24'd0, b[0]}, a);
      fork
        capture(10 * per + 1, s, found);
        begin repeat (3) @(posedge clk); bus_rd(BASE + 4, dm, a); end
      join
      checks++; if (!found) begin errors++; $display("FAIL frame_start timeout div %0d", per); end
      bad = 0;
      for (int i = 0; i <= 10 * per; i++) if (s[i] !== line_bit(b, per, i)) bad++;
      checks++; if (bad != 0) begin errors++;
        $display("FAIL frame_bits byte %h div %0d got %0d bad cycles want 0", b[0], per, bad); end
      checks++; if (dm !== 32'h6) begin errors++; $display("FAIL frame_busy got %h want 00000006", dm); end
      bus_rd(BASE + 4, d, a);
      checks++; if (d !== 32'h2) begin errors++; $display("FAIL frame_idle got %h want 00000002", d); end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d; logic a, found, ovf; logic [255:0] s; int bad;
    bus_wr(BASE + 12, 4'h1, 32'h0, a);
    mq.delete(); ovf = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      logic [7:0] v; v = 8'($urandom);
      bus_wr(BASE + 0, 4'h1, {24'd0, v}, a);
      if (mq.size() < DEPTH) mq.push_back(v); else ovf = 1'b1;
    end
    bus_rd(BASE + 4, d, a);
    checks++; if (d !== status_m(1'b0, ovf) || d !== 32'h809) begin errors++;
      $display("FAIL ovf_status got %h want %h", d, status_m(1'b0, ovf)); end
    bus_wr(BASE + 4, 4'h2, 32'h8, a);
    bus_rd(BASE + 4, d, a);
    checks++; if (d !== 32'h809) begin errors++; $display("FAIL ovf_noclear got %h want 00000809", d); end
    bus_wr(BASE + 4, 4'h1, 32'h8, a);
    ovf = 1'b0;
    bus_rd(BASE + 4, d, a);
    checks++; if (d !== status_m(1'b0, ovf)) begin errors++;
      $display("FAIL ovf_clear got %h want %h", d, status_m(1'b0, ovf)); end
    div_m = 16'd1;
    bus_wr(BASE + 8, 4'h3, 32'd1, a);
    bus_wr(BASE + 12, 4'h1, 32'h1, a);
    capture(10 * DEPTH + 1, s, found);
    bad = 0;
    for (int i = 0; i <= 10 * DEPTH; i++) if (s[i] !== line_bit(mq, 1, i)) bad++;
    checks++; if (!found || bad != 0) begin errors++;
      $display("FAIL drain_bits found %b got %0d bad cycles want 0", found, bad); end
    mq.delete();
    bus_rd(BASE + 4, d, a);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL drain_empty got %h want 00000002", d); end
  endtask

  task automatic test_back_to_back();
    logic a, found; logic [255:0] s; logic [7:0] b[$]; int bad;
    bus_wr(BASE + 12, 4'h1, 32'h0, a);
    b.delete(); b.push_back(8'h01); b.push_back(8'h80);
    bus_wr(BASE + 0, 4'h1, 32'h01, a);
    bus_wr(BASE + 0, 4'h1, 32'h80, a);
    bus_wr(BASE + 12, 4'h1, 32'h1, a);
    capture(22, s, found);
    bad = 0;
    for (int i = 0; i < 22; i++) if (s[i] !== line_bit(b, 1, i)) bad++;
    checks++; if (!found || bad != 0) begin errors++;
      $display("FAIL b2b_bits found %b got %0d bad cycles want 0", found, bad); end
  endtask

  task automatic test_irq();
    logic a, found; logic [255:0] s; logic [7:0] b[$]; int bad;
    bus_wr(BASE + 12, 4'h1, 32'h3, a);
    repeat (3) @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_drained got %b want 1", irq); end
    b.delete(); b.push_back(8'($urandom));
    bus_wr(BASE + 0, 4'h1, {24'd0, b[0]}, a);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_push got %b want 0", irq); end
    capture(10, s, found);
    bad = 0;
    for (int i = 0; i < 10; i++) if (s[i] !== line_bit(b, 1, i)) bad++;
    checks++; if (!found || bad != 0 || irq !== 1'b0) begin errors++;
      $display("FAIL irq_frame found %b bad %0d irq %b want 1/0/0", found, bad, irq); end
    found = 1'b0;
    for (int i = 0; i < 5 && !found; i++) begin @(posedge clk); #1; if (irq === 1'b1) found = 1'b1; end
    checks++; if (!found) begin errors++; $display("FAIL irq_reassert got 0 want 1"); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d; logic a;
    bus_wr(BASE + 8, 4'h3, 32'd4, a);
    bus_wr(BASE + 12, 4'h1, 32'h1, a);
    bus_wr(BASE + 0, 4'h1, {24'd0, 8'($urandom)}, a);
    bus_wr(BASE + 0, 4'h1, 32'hA5, a);
    repeat (15) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b want 1", tx); end
    @(negedge clk); rst = 1'b0;
    bus_rd(BASE + 4, d, a);
    checks++; if (d !== 32'h2) begin errors++; $display("FAIL rst_mid_status got %h want 00000002", d); end
    bus_rd(BASE + 8, d, a);
    checks++; if (d !== 32'd868) begin errors++; $display("FAIL rst_mid_div got %0d want 868", d); end
    bus_rd(BASE + 32'h10, d, a);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL out_of_range_ack got %b want 0", a); end
    repeat (50) @(posedge clk); #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got %b want 1", tx); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_frame();
    test_overflow();
    test_back_to_back();
    test_irq();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
